// File: rtl/subleq_exec.sv
// rtl/subleq_exec.sv - SUBLEQ execute sequencer: fetch, read A/B, subtract, write back, branch
// Five cycles per instruction against single-port synchronous data memory.
module subleq_exec #(
   parameter int              AW        = 8,
   parameter int              DW        = 8,
   parameter logic [AW-1:0]   HALT_ADDR = 8'hFF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              run,
   input  logic [3*AW-1:0]   instr_in,
   output logic              ir_en,
   output logic [AW-1:0]     pc,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic              mem_we,
   input  logic [DW-1:0]     mem_rdata,
   output logic              halted,
   output logic [15:0]       retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_RD_A, S_RD_B, S_LATCH_B, S_WB, S_HALT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_pc;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic [15:0]     r_retired;

   logic [AW-1:0]   w_a;
   logic [AW-1:0]   w_b;
   logic [AW-1:0]   w_c;
   logic [DW-1:0]   w_res;
   logic            w_taken;
   logic            w_halt;

   assign w_a     = instr_in[3*AW-1:2*AW];
   assign w_b     = instr_in[2*AW-1:AW];
   assign w_c     = instr_in[AW-1:0];
   // Branch decision uses the wrapped DW-bit difference, not the true one.
   assign w_res   = r_b - r_a;
   assign w_taken = w_res[DW-1] | (w_res == '0);
   assign w_halt  = w_taken && (w_c == HALT_ADDR);

   assign pc      = r_pc;
   assign retired = r_retired;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      ir_en     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      halted    = 1'b0;
      case (r_state)
         S_IDLE:    if (run) w_next = S_FETCH;
         S_FETCH: begin
            ir_en  = 1'b1;
            w_next = S_RD_A;
         end
         S_RD_A: begin
            mem_addr = w_a;
            w_next   = S_RD_B;
         end
         S_RD_B: begin
            mem_addr = w_b;
            w_next   = S_LATCH_B;
         end
         S_LATCH_B: w_next = S_WB;
         S_WB: begin
            mem_we    = 1'b1;
            mem_addr  = w_b;
            mem_wdata = w_res;
            if (w_halt)   w_next = S_HALT;
            else if (run) w_next = S_FETCH;
            else          w_next = S_IDLE;
         end
         S_HALT:    halted = 1'b1;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_pc      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_retired <= '0;
      end else begin
         case (r_state)
            S_RD_B:    r_a <= mem_rdata;
            S_LATCH_B: r_b <= mem_rdata;
            S_WB: begin
               r_retired <= r_retired + 16'd1;
               // A halting instruction leaves pc pointing at itself.
               if (!w_halt) r_pc <= w_taken ? w_c : r_pc + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_subleq_exec.sv
// tb/tb_subleq_exec.sv - directed bench for subleq_exec with instruction-level reference model
// Model predicts a 5-entry cycle trace per instruction; memories and IR live in the bench.
module tb_subleq_exec;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        run = 1'b0;
   logic [23:0] instr_in;
   logic        ir_en;
   logic [7:0]  pc;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = 8'h00;
   logic        halted;
   logic [15:0] retired;

   subleq_exec dut (
      .CLK(CLK), .RST(RST), .run(run), .instr_in(instr_in), .ir_en(ir_en), .pc(pc),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .halted(halted), .retired(retired)
   );

   always #5 CLK = ~CLK;

   logic [23:0] rom  [256];
   logic [7:0]  dmem [256];
   logic [23:0] ir_q = 24'h0;
   assign instr_in = ir_q;

   always @(posedge CLK) begin
      if (ir_en) ir_q <= rom[pc];
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      mem_rdata <= dmem[mem_addr];
   end

   int total = 0;
   int bad   = 0;
   int n_ir  = 0;
   int n_we  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one instruction executed at a time, expanded into its cycle trace.
   typedef struct {
      logic       ir;
      logic       we;
      logic       chk_addr;
      logic [7:0] addr;
      logic [7:0] wdata;
   } cyc_t;

   cyc_t        q[$];
   logic [7:0]  m_mem [256];
   logic [7:0]  m_pc = 8'h00, p_pc = 8'h00;
   logic [15:0] m_ret = 16'h0, p_ret = 16'h0;
   logic        m_halt = 1'b0, p_halt = 1'b0;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q.delete();
         m_pc = 8'h00; m_ret = 16'h0; m_halt = 1'b0;
      end else if (q.size() == 0 && !m_halt && run) begin
         logic [23:0] iw;
         logic [7:0]  a, b, c, r;
         logic        taken;
         iw = rom[m_pc];
         a = iw[23:16]; b = iw[15:8]; c = iw[7:0];
         r = m_mem[b] - m_mem[a];
         m_mem[b] = r;
         taken = r[7] || (r == 8'h00);
         p_ret  = m_ret + 16'd1;
         p_halt = taken && (c == 8'hFF);
         p_pc   = p_halt ? m_pc : (taken ? c : m_pc + 8'd1);
         q.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
         q.push_back('{1'b0, 1'b0, 1'b1, a,     8'h00});
         q.push_back('{1'b0, 1'b0, 1'b1, b,     8'h00});
         q.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
         q.push_back('{1'b0, 1'b1, 1'b1, b,     r});
      end
   end

   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         if (ir_en === 1'b1) n_ir++;
         if (mem_we === 1'b1) n_we++;
         if (q.size() > 0) begin
            cyc_t e;
            e = q.pop_front();
            chk("ir_en", ir_en, e.ir);
            chk("mem_we", mem_we, e.we);
            if (e.chk_addr) chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            chk("pc_busy", pc, m_pc);
            chk("retired_busy", retired, m_ret);
            chk("halted_busy", halted, 1'b0);
            if (q.size() == 0) begin
               m_pc = p_pc; m_ret = p_ret; m_halt = p_halt;
            end
         end else begin
            chk("ir_en_idle", ir_en, 1'b0);
            chk("mem_we_idle", mem_we, 1'b0);
            chk("pc_idle", pc, m_pc);
            chk("retired_idle", retired, m_ret);
            chk("halted_idle", halted, m_halt);
         end
      end
   end

   task automatic set_mem(input logic [7:0] addr, input logic [7:0] val);
      dmem[addr]  = val;
      m_mem[addr] = val;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      run = 1'b0;
      RST = 1'b0;
      #1;
      chk("rst_pc", pc, 8'h00);
      chk("rst_ir_en", ir_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_mem_wdata", mem_wdata, 8'h00);
      chk("rst_halted", halted, 1'b0);
      chk("rst_retired", retired, 16'h0);
      for (int i = 0; i < 256; i++) begin
         rom[i] = 24'h0;
         dmem[i] = 8'h00;
         m_mem[i] = 8'h00;
      end
      n_ir = 0;
      n_we = 0;
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic run_one();
      @(negedge CLK); run = 1'b1;
      @(negedge CLK); run = 1'b0;
      repeat (8) @(negedge CLK);
   endtask

   initial begin
      // Basic subtract, no branch
      do_reset();
      rom[0] = 24'h101120; set_mem(8'h10, 8'd3); set_mem(8'h11, 8'd5);
      run_one();
      chk("t1_m11", dmem[8'h11], 8'h02);
      chk("t1_pc", pc, 8'h01);
      chk("t1_retired", retired, 16'd1);
      chk("t1_n_ir", n_ir, 1);
      chk("t1_n_we", n_we, 1);

      // Zero result branches
      do_reset();
      rom[0] = 24'h101140; set_mem(8'h10, 8'd5); set_mem(8'h11, 8'd5);
      run_one();
      chk("t2_m11", dmem[8'h11], 8'h00);
      chk("t2_pc", pc, 8'h40);

      // Negative result branches
      do_reset();
      rom[0] = 24'h101140; set_mem(8'h10, 8'd6); set_mem(8'h11, 8'd5);
      run_one();
      chk("t3_m11", dmem[8'h11], 8'hFF);
      chk("t3_pc", pc, 8'h40);

      // Wrapped difference 0x80-0x01 = 0x7F is positive
      do_reset();
      rom[0] = 24'h101140; set_mem(8'h10, 8'h01); set_mem(8'h11, 8'h80);
      run_one();
      chk("t4_m11", dmem[8'h11], 8'h7F);
      chk("t4_pc", pc, 8'h01);

      // pc wraps 0xFF -> 0x00 on a not-taken instruction
      do_reset();
      rom[0] = 24'h1011FE; rom[8'hFE] = 24'h202100; rom[8'hFF] = 24'h202100;
      set_mem(8'h20, 8'd1); set_mem(8'h21, 8'd3);
      @(negedge CLK); run = 1'b1;
      repeat (12) @(negedge CLK);
      run = 1'b0;
      repeat (10) @(negedge CLK);
      chk("t5_m21", dmem[8'h21], 8'h01);
      chk("t5_pc", pc, 8'h00);
      chk("t5_retired", retired, 16'd3);

      // Halt is sticky and ignores run
      do_reset();
      rom[0] = 24'h1010FF; set_mem(8'h10, 8'h37);
      @(negedge CLK); run = 1'b1;
      repeat (10) @(negedge CLK);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK); run = ~run;
      end
      repeat (4) @(negedge CLK);
      chk("t6_m10", dmem[8'h10], 8'h00);
      chk("t6_halted", halted, 1'b1);
      chk("t6_pc", pc, 8'h00);
      chk("t6_retired", retired, 16'd1);
      chk("t6_n_ir", n_ir, 1);
      chk("t6_n_we", n_we, 1);

      // run dropped during RD_B: write-back completes, then idle; resume later
      do_reset();
      rom[0] = 24'h101120; rom[1] = 24'h121302;
      set_mem(8'h10, 8'd3); set_mem(8'h11, 8'd5); set_mem(8'h12, 8'd1); set_mem(8'h13, 8'd4);
      @(negedge CLK); run = 1'b1;
      repeat (3) @(negedge CLK);
      run = 1'b0;
      repeat (8) @(negedge CLK);
      chk("t7_m11", dmem[8'h11], 8'h02);
      chk("t7_pc", pc, 8'h01);
      chk("t7_n_ir", n_ir, 1);
      run_one();
      chk("t7_m13", dmem[8'h13], 8'h03);
      chk("t7_pc2", pc, 8'h02);
      chk("t7_retired", retired, 16'd2);
      chk("t7_n_ir2", n_ir, 2);

      // Asynchronous reset during write-back
      do_reset();
      rom[0] = 24'h101120; set_mem(8'h10, 8'd3); set_mem(8'h11, 8'd5);
      @(negedge CLK); run = 1'b1;
      repeat (5) @(negedge CLK);
      #2;
      chk("t8_we_before", mem_we, 1'b1);
      RST = 1'b0;
      run = 1'b0;
      #1;
      chk("t8_we", mem_we, 1'b0);
      chk("t8_ir_en", ir_en, 1'b0);
      chk("t8_addr", mem_addr, 8'h00);
      chk("t8_wdata", mem_wdata, 8'h00);
      chk("t8_pc", pc, 8'h00);
      chk("t8_retired", retired, 16'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (4) @(negedge CLK);
      chk("t8_m11", dmem[8'h11], 8'h05);
      chk("t8_pc_after", pc, 8'h00);
      chk("t8_n_ir", n_ir, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/subleq_exec.md
Name: subleq_exec

Overview:
- Execute sequencer for the SUBLEQ OISC core. Sits directly downstream of the 24-bit instruction register and consumes its instr_out.
- Drives the register's load enable and the instruction ROM address (pc).
- Runs the read-A / read-B / subtract / write-back / branch sequence against single-port synchronous data memory.
- Takes 5 cycles per instruction.

Parameters:
- AW, 8, address width of the pc and of every instruction field (instruction word = 3*AW = 24 bits)
- DW, 8, data memory word width; two's complement
- HALT_ADDR, 8'hFF, branch target that halts the machine when the branch is taken

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- run  in  1  start/continue execution
- instr_in  in  24  from instruction register instr_out; A=[23:16], B=[15:8], C=[7:0]
- ir_en  out  1  load enable to instruction register
- pc  out  AW  instruction ROM address (ROM is combinational)
- mem_addr  out  AW  data memory address
- mem_wdata  out  DW  data memory write data
- mem_we  out  1  data memory write enable
- mem_rdata  in  DW  data memory read data, valid one cycle after mem_addr
- halted  out  1  sticky halt flag
- retired  out  16  count of completed instructions, wraps at 16'hFFFF->0

Behaviour:
- Reset (RST low, async): state=IDLE; pc=0, ir_en=0, mem_addr=0, mem_wdata=0, mem_we=0, halted=0, retired=0; internal a_reg=b_reg=0. All outputs are registered or decoded from the state register; no glitches.
- States and transitions:
  - IDLE: all enables low. Goes to FETCH when run=1.
  - FETCH: ir_en=1, pc stable. The instruction register captures ROM[pc] at the end of this cycle. Always goes to RD_A.
  - RD_A: mem_addr=A. Goes to RD_B.
  - RD_B: mem_addr=B; a_reg<=mem_rdata (M[A]). Goes to LATCH_B.
  - LATCH_B: b_reg<=mem_rdata (M[B]). Goes to WB.
  - WB: mem_we=1, mem_addr=B, mem_wdata=res, where res = b_reg - a_reg (DW bits, wraps, no saturation).
    - Taken = res[DW-1] | (res==0).
    - pc <= taken ? C : pc+1 (mod 2^AW; 8'hFF+1 -> 8'h00).
    - retired increments.
    - If taken and C==HALT_ADDR: go to HALT, and pc holds the halting instruction's address rather than loading C.
    - Else if run=1: go to FETCH; else go to IDLE.
  - HALT: halted=1, all enables low. Sticky until reset; run is ignored.
- Data timing: ir_en is high exactly one cycle per instruction. mem_we is high exactly one cycle per instruction (WB only).
- instr_in is sampled only in RD_A through WB, and is stable from the FETCH edge onward.
- Overflow: taken is evaluated on the wrapped DW-bit result, never on the true difference.
- A==B is legal: result is 0, the branch is taken, and M[A] is written 0.
- B==C aliasing has no effect (separate address spaces).
- run deasserted mid-instruction: the current instruction completes, including write-back, then the block goes to IDLE with pc already updated. Reasserting run resumes at FETCH.
- Reset mid-instruction: immediate abort, no partial write. If RST falls during WB, mem_we drops asynchronously.
- Throughput: 5 cycles/instruction. Latency from run rising in IDLE to first ir_en: 1 cycle.

Test Plan:
- Basic subtract, no branch: M[0x10]=3, M[0x11]=5, ROM[0]=0x101120, run=1 -> ir_en one cycle; M[0x11]=2 written in cycle 5; pc=0x01; retired=1; mem_we high for exactly 1 cycle.
- Branch on zero: M[0x10]=5, M[0x11]=5, ROM[0]=0x101140 -> M[0x11]=0, pc=0x40. With M[0x10]=6 instead -> M[0x11]=0xFF and pc=0x40 (negative result also branches).
- Wrap: M[0x10]=0x01, M[0x11]=0x80 -> res=0x7F, not taken, pc=1. Separately, pc=0xFF with a not-taken instruction -> pc=0x00.
- Halt: ROM[0]=0x1010FF with any M[0x10] -> M[0x10]=0, halted=1, pc=0x00. Toggling run afterwards -> no further ir_en or mem_we.
- run drop: deassert run during RD_B of instruction 1 -> write-back completes, pc=1, block enters IDLE, no ir_en. Reassert run -> instruction at pc=1 executes.
- Async reset: assert RST low during WB -> mem_we=0 and all outputs at reset values within the same cycle, no clock required. Release RST -> IDLE, pc=0.
